// File: rtl/frac_n_modulus_controller.sv
// frac_n_modulus_controller: first-order accumulator picking 240/248 divide ratio per freq_in cycle; frac_word/valid/ready load, select_mode/period_count/sel_count out
module frac_n_modulus_controller #(
  parameter int ACC_WIDTH = 8
) (
  input  logic                 freq_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] frac_word,
  input  logic                 frac_valid,
  output logic                 frac_ready,
  output logic                 select_mode,
  output logic [ACC_WIDTH-1:0] period_count,
  output logic [ACC_WIDTH:0]   sel_count
);
  localparam int W = ACC_WIDTH;
  logic [W-1:0] acc_q, acc_d, active_q, active_d, shadow_q, shadow_d, period_q, period_d;
  logic         pending_q, pending_d, sel_q, sel_d, wrap;
  logic [W:0]   tally_q, tally_d, cnt_q, cnt_d, sum;
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, active_q};
    wrap      = enable & (period_q == '1);
    pending_d = frac_valid & ~pending_q;
    shadow_d  = pending_d ? frac_word : shadow_q;
    active_d  = pending_q ? shadow_q : active_q;
    acc_d     = enable ? sum[W-1:0] : acc_q;
    sel_d     = enable & sum[W];
    period_d  = enable ? period_q + W'(1) : period_q;
    tally_d   = wrap ? '0 : tally_q + (W+1)'(sel_d);
    cnt_d     = wrap ? tally_q + (W+1)'(sel_d) : cnt_q;
  end
  always_ff @(posedge freq_in or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      sel_q     <= 1'b0;
      tally_q   <= '0;
      cnt_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      tally_q   <= tally_d;
      cnt_q     <= cnt_d;
    end
  end
  assign frac_ready   = ~pending_q;
  assign select_mode  = sel_q;
  assign period_count = period_q;
  assign sel_count    = cnt_q;
endmodule

// File: tb/tb_frac_n_modulus_controller.sv
// tb_frac_n_modulus_controller: directed checks of the fractional-N modulus controller
module tb_frac_n_modulus_controller;
  logic       freq_in = 1'b0, reset = 1'b1, enable = 1'b0, frac_valid = 1'b0;
  logic [7:0] frac_word = '0;
  logic       frac_ready, select_mode;
  logic [7:0] period_count;
  logic [8:0] sel_count;
  int errors = 0, checks = 0;
  always #5 freq_in = ~freq_in;
  frac_n_modulus_controller #(.ACC_WIDTH(8)) dut (
    .freq_in(freq_in), .reset(reset), .enable(enable), .frac_word(frac_word),
    .frac_valid(frac_valid), .frac_ready(frac_ready), .select_mode(select_mode),
    .period_count(period_count), .sel_count(sel_count)
  );
  task automatic tick;
    @(negedge freq_in);
  endtask
  task automatic do_reset;
    @(negedge freq_in);
    enable = 1'b0;
    frac_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask
  task automatic load(input logic [7:0] w);
    frac_word = w;
    frac_valid = 1'b1;
    tick();
    frac_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    #2;
    checks++; if (select_mode !== 1'b0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", select_mode); end
    checks++; if (frac_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", frac_ready); end
    checks++; if (period_count !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_count); end
    checks++; if (sel_count !== 9'd0) begin errors++; $display("FAIL reset_selcnt: got %0d expected 0", sel_count); end
    reset = 1'b0;
  endtask
  task automatic test_frac_zero;
    int ones = 0;
    do_reset();
    load(8'd0);
    enable = 1'b1;
    for (int i = 1; i <= 512; i++) begin
      tick();
      ones += int'(select_mode);
      if (i == 256) begin
        checks++; if (sel_count !== 9'd0) begin errors++; $display("FAIL zero_selcnt_w1: got %0d expected 0", sel_count); end
      end
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL zero_selects: got %0d expected 0", ones); end
    checks++; if (period_count !== 8'd0) begin errors++; $display("FAIL zero_period: got %0d expected 0", period_count); end
    checks++; if (sel_count !== 9'd0) begin errors++; $display("FAIL zero_selcnt_w2: got %0d expected 0", sel_count); end
  endtask
  task automatic test_half;
    do_reset();
    load(8'd128);
    enable = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i <= 8) begin
        checks++; if (select_mode !== 1'((i % 2) == 0)) begin errors++; $display("FAIL half_pattern[%0d]: got %0d expected %0d", i, select_mode, (i % 2) == 0); end
      end
    end
    checks++; if (sel_count !== 9'd128) begin errors++; $display("FAIL half_selcnt: got %0d expected 128", sel_count); end
    checks++; if (period_count !== 8'd0) begin errors++; $display("FAIL half_period: got %0d expected 0", period_count); end
  endtask
  task automatic test_extremes;
    int ones = 0;
    do_reset();
    load(8'd1);
    enable = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      ones += int'(select_mode);
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL min_early_selects: got %0d expected 0", ones); end
    tick();
    checks++; if (select_mode !== 1'b1) begin errors++; $display("FAIL min_last_select: got %0d expected 1", select_mode); end
    checks++; if (sel_count !== 9'd1) begin errors++; $display("FAIL min_selcnt: got %0d expected 1", sel_count); end
    enable = 1'b0;
    load(8'd255);
    enable = 1'b1;
    repeat (256) tick();
    checks++; if (sel_count !== 9'd255) begin errors++; $display("FAIL max_selcnt: got %0d expected 255", sel_count); end
  endtask
  task automatic test_handshake;
    logic [7:0] pat = '0;
    do_reset();
    enable = 1'b1;
    frac_word = 8'd64;
    frac_valid = 1'b1;
    checks++; if (frac_ready !== 1'b1) begin errors++; $display("FAIL hs_ready0: got %0d expected 1", frac_ready); end
    tick(); pat[0] = select_mode;
    checks++; if (frac_ready !== 1'b0) begin errors++; $display("FAIL hs_ready1: got %0d expected 0", frac_ready); end
    frac_word = 8'd32;
    tick(); pat[1] = select_mode;
    checks++; if (frac_ready !== 1'b1) begin errors++; $display("FAIL hs_ready2: got %0d expected 1", frac_ready); end
    tick(); pat[2] = select_mode;
    checks++; if (frac_ready !== 1'b0) begin errors++; $display("FAIL hs_ready3: got %0d expected 0", frac_ready); end
    frac_valid = 1'b0;
    tick(); pat[3] = select_mode;
    checks++; if (frac_ready !== 1'b1) begin errors++; $display("FAIL hs_ready4: got %0d expected 1", frac_ready); end
    for (int i = 4; i < 8; i++) begin
      tick();
      pat[i] = select_mode;
    end
    checks++; if (pat !== 8'b1000_0000) begin errors++; $display("FAIL hs_pattern: got %b expected 10000000", pat); end
  endtask
  task automatic test_enable_gap;
    logic [4:0] pre = '0;
    logic [3:0] post = '0;
    int ones = 0;
    do_reset();
    load(8'd64);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pre[i] = select_mode;
    end
    checks++; if (pre !== 5'b01000) begin errors++; $display("FAIL gap_pre_pattern: got %b expected 01000", pre); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ones += int'(select_mode);
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL gap_selects: got %0d expected 0", ones); end
    checks++; if (period_count !== 8'd5) begin errors++; $display("FAIL gap_period: got %0d expected 5", period_count); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      post[i] = select_mode;
    end
    checks++; if (post !== 4'b0100) begin errors++; $display("FAIL gap_post_pattern: got %b expected 0100", post); end
    checks++; if (period_count !== 8'd9) begin errors++; $display("FAIL gap_post_period: got %0d expected 9", period_count); end
  endtask
  task automatic test_async_reset;
    int ones = 0;
    do_reset();
    load(8'd200);
    enable = 1'b1;
    repeat (256) tick();
    checks++; if (sel_count !== 9'd200) begin errors++; $display("FAIL ar_selcnt_pre: got %0d expected 200", sel_count); end
    repeat (2) tick();
    frac_word = 8'd200;
    frac_valid = 1'b1;
    tick();
    checks++; if (frac_ready !== 1'b0) begin errors++; $display("FAIL ar_pending: got %0d expected 0", frac_ready); end
    frac_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (select_mode !== 1'b0) begin errors++; $display("FAIL ar_sel: got %0d expected 0", select_mode); end
    checks++; if (frac_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %0d expected 1", frac_ready); end
    checks++; if (period_count !== 8'd0) begin errors++; $display("FAIL ar_period: got %0d expected 0", period_count); end
    checks++; if (sel_count !== 9'd0) begin errors++; $display("FAIL ar_selcnt: got %0d expected 0", sel_count); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ones += int'(select_mode);
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL ar_word_lost: got %0d expected 0", ones); end
    checks++; if (period_count !== 8'd3) begin errors++; $display("FAIL ar_restart_period: got %0d expected 3", period_count); end
  endtask
  initial begin
    test_reset();
    test_frac_zero();
    test_half();
    test_extremes();
    test_handshake();
    test_enable_gap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
